// File: rtl/ddr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_sched_pkg
// Brief    : Section/FSM state types and descriptor address helper shared by
//            the DDR frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    SEC_FREE    = 2'd0,
    SEC_WRITING = 2'd1,
    SEC_READY   = 2'd2,
    SEC_READING = 2'd3
  } sec_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RUN  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RUN  = 2'd2
  } rd_state_e;

  // Section index sits directly above the frame offset; bank bits stay zero.
  function automatic logic [63:0] desc_addr(input logic [31:0] sec, input int len_w);
    return {32'd0, sec} << len_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_sched_desc_port.sv
`default_nettype none
// ============================================================================
// Module   : ddr_sched_desc_port
// Brief    : Single-entry descriptor holding stage; address/length stay stable
//            from load until the valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_sched_desc_port #(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 19
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  cfg_valid,
  input  logic                  cfg_ready
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_addr  <= load_addr;
      r_len   <= load_len;
      r_valid <= 1'b1;
    end else if (r_valid && cfg_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign cfg_addr  = r_addr;
  assign cfg_len   = r_len;
  assign cfg_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr_frame_sched
// Brief    : DDR frame-section allocator issuing write/read DMA descriptors;
//            the reader always gets the newest complete frame and never a
//            section under write. DDR_SCHED_REPEAT_EN allows re-reading the
//            same frame; otherwise only fresh frames are served.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_frame_sched
  import ddr_sched_pkg::*;
#(
  parameter int SEC_WIDTH       = 2,
  parameter int LEN_WIDTH       = 19,
  parameter int BANK_WIDTH      = 3,
  parameter int MAX_LEN         = 518400,
  parameter int DESC_ADDR_WIDTH = BANK_WIDTH + SEC_WIDTH + LEN_WIDTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       wr_start,
  input  logic                       rd_start,
  output logic [DESC_ADDR_WIDTH-1:0] wr_cfg_addr,
  output logic [LEN_WIDTH-1:0]       wr_cfg_len,
  output logic                       wr_cfg_valid,
  input  logic                       wr_cfg_ready,
  input  logic                       wr_done,
  output logic [DESC_ADDR_WIDTH-1:0] rd_cfg_addr,
  output logic [LEN_WIDTH-1:0]       rd_cfg_len,
  output logic                       rd_cfg_valid,
  input  logic                       rd_cfg_ready,
  input  logic                       rd_done,
  output logic [SEC_WIDTH-1:0]       wr_sec,
  output logic [SEC_WIDTH-1:0]       rd_sec,
  output logic                       frame_avail,
  output logic                       wr_ovr,
  output logic                       rd_skip
);

  localparam int                   c_num_sec = 2 ** SEC_WIDTH;
  localparam logic [LEN_WIDTH-1:0] c_len     = LEN_WIDTH'(MAX_LEN);

  wr_state_e            r_wr_st, w_wr_st_nxt;
  rd_state_e            r_rd_st, w_rd_st_nxt;
  sec_state_e           r_sec_st     [c_num_sec];
  sec_state_e           w_sec_st_nxt [c_num_sec];
  logic [SEC_WIDTH-1:0] r_latest, w_latest_nxt, r_wr_sec, w_wr_sec_nxt;
  logic [SEC_WIDTH-1:0] r_rd_sec, w_rd_sec_nxt, w_pick;
  logic                 r_latest_vld, w_latest_vld_nxt;
  logic                 r_wr_ovr, w_wr_ovr_nxt, r_rd_skip, w_rd_skip_nxt;
  logic                 w_pick_ok, w_wr_done_evt, w_rd_serviceable, w_wr_load, w_rd_load;
  logic [DESC_ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
`ifndef DDR_SCHED_REPEAT_EN
  logic                 r_fresh, w_fresh_nxt;
`endif

  always_comb begin
    w_wr_st_nxt   = r_wr_st;
    w_rd_st_nxt   = r_rd_st;
    w_sec_st_nxt  = r_sec_st;
    w_wr_sec_nxt  = r_wr_sec;
    w_rd_sec_nxt  = r_rd_sec;
    w_wr_ovr_nxt  = 1'b0;
    w_rd_skip_nxt = 1'b0;
    w_wr_load     = 1'b0;
    w_rd_load     = 1'b0;
    w_pick        = '0;
    w_pick_ok     = 1'b0;
    for (int i = c_num_sec - 1; i >= 0; i--) begin
      if (r_sec_st[i] == SEC_FREE && !(r_latest_vld && r_latest == SEC_WIDTH'(i))) begin
        w_pick    = SEC_WIDTH'(i);
        w_pick_ok = 1'b1;
      end
    end
    // The read side sees the post-completion view of "latest" (same-cycle bypass).
    w_wr_done_evt    = (r_wr_st == W_RUN) && wr_done;
    w_latest_nxt     = w_wr_done_evt ? r_wr_sec : r_latest;
    w_latest_vld_nxt = w_wr_done_evt | r_latest_vld;
`ifdef DDR_SCHED_REPEAT_EN
    w_rd_serviceable = w_latest_vld_nxt;
`else
    w_fresh_nxt      = w_wr_done_evt | r_fresh;
    w_rd_serviceable = w_latest_vld_nxt && w_fresh_nxt;
`endif

    case (r_wr_st)
      W_IDLE: begin
        if (wr_start) begin
          if (w_pick_ok) begin
            w_wr_load              = 1'b1;
            w_wr_sec_nxt           = w_pick;
            w_sec_st_nxt[w_pick]   = SEC_WRITING;
            w_wr_st_nxt            = W_REQ;
          end else begin
            w_wr_ovr_nxt = 1'b1;
          end
        end
      end
      W_REQ: begin
        w_wr_ovr_nxt = wr_start;
        if (wr_cfg_ready) w_wr_st_nxt = W_RUN;
      end
      W_RUN: begin
        w_wr_ovr_nxt = wr_start;
        if (wr_done) begin
          if (r_latest_vld && r_latest != r_wr_sec && r_sec_st[r_latest] != SEC_READING)
            w_sec_st_nxt[r_latest] = SEC_FREE;
          w_sec_st_nxt[r_wr_sec] = SEC_READY;
          w_wr_st_nxt            = W_IDLE;
        end
      end
      default: w_wr_st_nxt = W_IDLE;
    endcase

    // Read edits come last so a section re-taken or released by the reader wins.
    case (r_rd_st)
      R_IDLE: begin
        if (rd_start) begin
          if (w_rd_serviceable) begin
            w_rd_load                  = 1'b1;
            w_rd_sec_nxt               = w_latest_nxt;
            w_sec_st_nxt[w_latest_nxt] = SEC_READING;
            w_rd_st_nxt                = R_REQ;
`ifndef DDR_SCHED_REPEAT_EN
            w_fresh_nxt                = 1'b0;
`endif
          end else begin
            w_rd_skip_nxt = 1'b1;
          end
        end
      end
      R_REQ: begin
        w_rd_skip_nxt = rd_start;
        if (rd_cfg_ready) w_rd_st_nxt = R_RUN;
      end
      R_RUN: begin
        w_rd_skip_nxt = rd_start;
        if (rd_done) begin
          w_sec_st_nxt[r_rd_sec] = (w_latest_vld_nxt && w_latest_nxt == r_rd_sec) ?
                                   SEC_READY : SEC_FREE;
          w_rd_st_nxt            = R_IDLE;
        end
      end
      default: w_rd_st_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_st      <= W_IDLE;
      r_rd_st      <= R_IDLE;
      for (int i = 0; i < c_num_sec; i++) r_sec_st[i] <= SEC_FREE;
      r_latest     <= '0;
      r_latest_vld <= 1'b0;
      r_wr_sec     <= '0;
      r_rd_sec     <= '0;
      r_wr_ovr     <= 1'b0;
      r_rd_skip    <= 1'b0;
`ifndef DDR_SCHED_REPEAT_EN
      r_fresh      <= 1'b0;
`endif
    end else begin
      r_wr_st      <= w_wr_st_nxt;
      r_rd_st      <= w_rd_st_nxt;
      r_sec_st     <= w_sec_st_nxt;
      r_latest     <= w_latest_nxt;
      r_latest_vld <= w_latest_vld_nxt;
      r_wr_sec     <= w_wr_sec_nxt;
      r_rd_sec     <= w_rd_sec_nxt;
      r_wr_ovr     <= w_wr_ovr_nxt;
      r_rd_skip    <= w_rd_skip_nxt;
`ifndef DDR_SCHED_REPEAT_EN
      r_fresh      <= w_fresh_nxt;
`endif
    end
  end

  assign w_wr_addr = DESC_ADDR_WIDTH'(desc_addr(32'(w_pick), LEN_WIDTH));
  assign w_rd_addr = DESC_ADDR_WIDTH'(desc_addr(32'(w_latest_nxt), LEN_WIDTH));

  ddr_sched_desc_port #(.ADDR_WIDTH(DESC_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_wr_port (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (w_wr_load),
    .load_addr (w_wr_addr),
    .load_len  (c_len),
    .cfg_addr  (wr_cfg_addr),
    .cfg_len   (wr_cfg_len),
    .cfg_valid (wr_cfg_valid),
    .cfg_ready (wr_cfg_ready)
  );

  ddr_sched_desc_port #(.ADDR_WIDTH(DESC_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_rd_port (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (w_rd_load),
    .load_addr (w_rd_addr),
    .load_len  (c_len),
    .cfg_addr  (rd_cfg_addr),
    .cfg_len   (rd_cfg_len),
    .cfg_valid (rd_cfg_valid),
    .cfg_ready (rd_cfg_ready)
  );

  assign wr_sec      = r_wr_sec;
  assign rd_sec      = r_rd_sec;
  assign frame_avail = r_latest_vld;
  assign wr_ovr      = r_wr_ovr;
  assign rd_skip     = r_rd_skip;

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_frame_sched
// Brief    : Self-checking bench for ddr_frame_sched: directed scenarios with
//            literal expectations plus randomized traffic against a
//            section-occupancy reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_frame_sched;

  localparam int SW   = 2;
  localparam int LW   = 19;
  localparam int AW   = 24;
  localparam int ML   = 518400;
  localparam int NSEC = 4;
`ifdef DDR_SCHED_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic aclk = 1'b0, aresetn = 1'b1;
  logic wr_start = 1'b0, rd_start = 1'b0, wr_cfg_ready = 1'b0, wr_done = 1'b0;
  logic rd_cfg_ready = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] wr_cfg_addr, rd_cfg_addr;
  logic [LW-1:0] wr_cfg_len, rd_cfg_len;
  logic          wr_cfg_valid, rd_cfg_valid, frame_avail, wr_ovr, rd_skip;
  logic [SW-1:0] wr_sec, rd_sec;

  int n_vec = 0, n_err = 0;

  // Reference model: which section each side holds and which frame is newest.
  int m_wph, m_wsec, m_rph, m_rsec, m_lat;
  bit m_lvld, m_fresh, m_ovr, m_skip;

  always #5 aclk = ~aclk;

  ddr_frame_sched dut (
    .aclk(aclk), .aresetn(aresetn), .wr_start(wr_start), .rd_start(rd_start),
    .wr_cfg_addr(wr_cfg_addr), .wr_cfg_len(wr_cfg_len), .wr_cfg_valid(wr_cfg_valid),
    .wr_cfg_ready(wr_cfg_ready), .wr_done(wr_done),
    .rd_cfg_addr(rd_cfg_addr), .rd_cfg_len(rd_cfg_len), .rd_cfg_valid(rd_cfg_valid),
    .rd_cfg_ready(rd_cfg_ready), .rd_done(rd_done),
    .wr_sec(wr_sec), .rd_sec(rd_sec), .frame_avail(frame_avail),
    .wr_ovr(wr_ovr), .rd_skip(rd_skip)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wph = 0; m_wsec = 0; m_rph = 0; m_rsec = 0; m_lat = 0;
    m_lvld = 0; m_fresh = 0; m_ovr = 0; m_skip = 0;
  endtask

  task automatic model_step();
    int nlat    = m_lat;
    bit nlvld   = m_lvld;
    bit nfresh  = m_fresh;
    int pick    = -1;
    bit wdone   = (m_wph == 2) && wr_done;
    if (wdone) begin nlat = m_wsec; nlvld = 1'b1; nfresh = 1'b1; end
    // writable = neither the newest frame nor the one being read; lowest wins
    for (int s = NSEC - 1; s >= 0; s--)
      if (!(m_lvld && s == m_lat) && !(m_rph != 0 && s == m_rsec)) pick = s;
    m_ovr = wr_start && (m_wph != 0);
    case (m_wph)
      0:       if (wr_start && pick >= 0) begin m_wsec = pick; m_wph = 1; end
      1:       if (wr_cfg_ready) m_wph = 2;
      default: if (wr_done) m_wph = 0;
    endcase
    m_skip = rd_start && (m_rph != 0);
    case (m_rph)
      0: if (rd_start) begin
           if (nlvld && (REPEAT || nfresh)) begin
             m_rsec = nlat; m_rph = 1; nfresh = 1'b0;
           end else m_skip = 1'b1;
         end
      1:       if (rd_cfg_ready) m_rph = 2;
      default: if (rd_done) m_rph = 0;
    endcase
    m_lat = nlat; m_lvld = nlvld; m_fresh = nfresh;
  endtask

  task automatic compare_all();
    chk("wr_cfg_valid", 64'(wr_cfg_valid), 64'(m_wph == 1));
    chk("rd_cfg_valid", 64'(rd_cfg_valid), 64'(m_rph == 1));
    chk("wr_sec", 64'(wr_sec), 64'(m_wsec));
    chk("rd_sec", 64'(rd_sec), 64'(m_rsec));
    chk("frame_avail", 64'(frame_avail), 64'(m_lvld));
    chk("wr_ovr", 64'(wr_ovr), 64'(m_ovr));
    chk("rd_skip", 64'(rd_skip), 64'(m_skip));
    if (m_wph == 1) begin
      chk("wr_cfg_addr", 64'(wr_cfg_addr), 64'(m_wsec) << LW);
      chk("wr_cfg_len", 64'(wr_cfg_len), 64'(ML));
    end
    if (m_rph == 1) begin
      chk("rd_cfg_addr", 64'(rd_cfg_addr), 64'(m_rsec) << LW);
      chk("rd_cfg_len", 64'(rd_cfg_len), 64'(ML));
    end
  endtask

  // Inputs change at posedge+1; outputs are compared one time unit after the edge.
  task automatic step(input bit ws, input bit wrdy, input bit wd,
                      input bit rs, input bit rrdy, input bit rdn);
    wr_start = ws; wr_cfg_ready = wrdy; wr_done = wd;
    rd_start = rs; rd_cfg_ready = rrdy; rd_done = rdn;
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #3 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    model_reset();
    compare_all();
    chk("lit_rst_wr_valid", 64'(wr_cfg_valid), 64'h0);
    chk("lit_rst_wr_addr", 64'(wr_cfg_addr), 64'h0);
    chk("lit_rst_rd_valid", 64'(rd_cfg_valid), 64'h0);
    chk("lit_rst_avail", 64'(frame_avail), 64'h0);
    chk("lit_rst_secs", 64'({wr_sec, rd_sec}), 64'h0);
    chk("lit_rst_pulses", 64'({wr_ovr, rd_skip}), 64'h0);
    aresetn = 1'b1;

    step(0,0,0,1,0,0);
    chk("lit_skip_noframe", 64'(rd_skip), 64'h1);
    chk("lit_skip_noframe_valid", 64'(rd_cfg_valid), 64'h0);

    // frame 1 -> section 0, ready three cycles after start
    step(1,0,0,0,0,0);
    chk("lit_f1_valid", 64'(wr_cfg_valid), 64'h1);
    chk("lit_f1_addr", 64'(wr_cfg_addr), 64'h000000);
    chk("lit_f1_len", 64'(wr_cfg_len), 64'd518400);
    step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,1,0,0,0,0);
    chk("lit_f1_valid_fall", 64'(wr_cfg_valid), 64'h0);
    step(0,0,1,0,0,0);
    chk("lit_f1_avail", 64'(frame_avail), 64'h1);

    // frame 2 -> section 1, with an overrun start during W_RUN
    step(1,0,0,0,0,0);
    chk("lit_f2_sec", 64'(wr_sec), 64'h1);
    chk("lit_f2_addr", 64'(wr_cfg_addr), 64'h080000);
    step(0,1,0,0,0,0);
    step(1,0,0,0,0,0);
    chk("lit_ovr_pulse", 64'(wr_ovr), 64'h1);
    chk("lit_ovr_sec_kept", 64'(wr_sec), 64'h1);
    step(0,0,0,0,0,0);
    chk("lit_ovr_once", 64'(wr_ovr), 64'h0);
    step(0,0,1,0,0,0);

    // frame 3 reuses section 0 (freed when frame 2 completed)
    step(1,0,0,0,0,0);
    chk("lit_f3_sec", 64'(wr_sec), 64'h0);
    step(0,1,0,0,0,0); step(0,0,1,0,0,0);

    // long read of section 0 while three frames complete
    step(0,0,0,1,0,0);
    chk("lit_rd1_valid", 64'(rd_cfg_valid), 64'h1);
    chk("lit_rd1_addr", 64'(rd_cfg_addr), 64'h000000);
    step(0,0,0,0,1,0);
    step(1,0,0,0,0,0);
    chk("lit_f4_sec", 64'(wr_sec), 64'h1);
    step(0,1,0,0,0,0); step(0,0,1,0,0,0);
    step(1,0,0,0,0,0);
    chk("lit_f5_sec", 64'(wr_sec), 64'h2);
    chk("lit_f5_addr", 64'(wr_cfg_addr), 64'h100000);
    step(0,1,0,0,0,0); step(0,0,1,0,0,0);
    step(1,0,0,0,0,0);
    chk("lit_f6_sec", 64'(wr_sec), 64'h1);
    step(0,1,0,0,0,0); step(0,0,1,0,0,0);
    step(0,0,0,0,0,1);

    // read newest (section 1), then ask again with no new frame
    step(0,0,0,1,0,0);
    chk("lit_rd2_sec", 64'(rd_sec), 64'h1);
    chk("lit_rd2_addr", 64'(rd_cfg_addr), 64'h080000);
    step(0,0,0,0,1,0); step(0,0,0,0,0,1);
    step(0,0,0,1,0,0);
`ifdef DDR_SCHED_REPEAT_EN
    chk("lit_reread_valid", 64'(rd_cfg_valid), 64'h1);
    chk("lit_reread_sec", 64'(rd_sec), 64'h1);
    step(0,0,0,0,1,0); step(0,0,0,0,0,1);
`else
    chk("lit_stale_skip", 64'(rd_skip), 64'h1);
    chk("lit_stale_valid", 64'(rd_cfg_valid), 64'h0);
`endif

    // section 0 was freed by the earlier rd_done; read start coincides with wr_done
    step(1,0,0,0,0,0);
    chk("lit_f7_sec", 64'(wr_sec), 64'h0);
    step(0,1,0,0,0,0);
    step(0,0,1,1,0,0);
    chk("lit_bypass_valid", 64'(rd_cfg_valid), 64'h1);
    chk("lit_bypass_sec", 64'(rd_sec), 64'h0);
    chk("lit_bypass_addr", 64'(rd_cfg_addr), 64'h000000);
    step(0,0,0,0,1,0); step(0,0,0,0,0,1);

    // reset while a write descriptor is pending
    step(1,0,0,0,0,0);
    aresetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("lit_midrst_valid", 64'(wr_cfg_valid), 64'h0);
    chk("lit_midrst_avail", 64'(frame_avail), 64'h0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    step(0,0,0,0,0,0); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    chk("lit_no_replay", 64'(wr_cfg_valid), 64'h0);

    // randomized traffic; the DMA side only signals done while its transfer runs
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1,
           (m_wph == 2) && ($urandom_range(0, 3) == 0),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1,
           (m_rph == 2) && ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
